// File: rtl/frac_search_ctrl.sv
// Sequencer for the fractional motion-search datapath: fetches the filter lines of one block,
// tags each line as prime-only or prime+reference, then waits out the datapath pipeline.
module frac_search_ctrl #(
    parameter int TAPS     = 8,
    parameter int HMAX     = 16,
    parameter int PIPE_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] blk_h,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       line_req,
    input  logic       line_ack,
    output logic       filter_valid,
    output logic       ref_valid,
    output logic [4:0] line_idx,
    output logic       last_line
);

    localparam int CW = $clog2(HMAX + TAPS);
    localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [CW-1:0] PRIME_N    = CW'(TAPS - 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_LAT);
    localparam logic [4:0]    HMAX_L     = 5'(HMAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] n_r, n_s, cnt_r, cnt_s;
    logic [DW-1:0] drain_r, drain_s;
    logic          busy_r, done_r, err_r, req_r, fv_r, rv_r, last_r;
    logic [4:0]    idx_r, idx_s;
    logic          done_s, err_s, fv_s, rv_s, last_s, req_s, busy_s;
    logic          accept_s, legal_s;

    assign accept_s = req_r & line_ack;
    assign legal_s  = (blk_h != 5'd0) && (blk_h <= HMAX_L);

    // Next-state, counter and strobe computation
    always_comb begin
        state_s = state_r;
        n_s     = n_r;
        cnt_s   = cnt_r;
        drain_s = drain_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        idx_s   = idx_r;
        fv_s    = accept_s;
        rv_s    = accept_s && (cnt_r >= PRIME_N);
        last_s  = accept_s && (cnt_r == n_r - CW'(1));
        if (accept_s) begin
            idx_s = 5'(cnt_r);
            cnt_s = cnt_r + CW'(1);
        end else begin
            cnt_s = cnt_r;
        end
        case (state_r)
            S_IDLE: begin
                if (start && legal_s) begin
                    n_s     = CW'(blk_h) + PRIME_N;
                    cnt_s   = {CW{1'b0}};
                    state_s = (TAPS == 1) ? S_RUN : S_PRIME;
                end else begin
                    err_s = start;
                end
            end
            S_PRIME: begin
                if (accept_s && (cnt_s == PRIME_N)) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_PRIME;
                end
            end
            S_RUN: begin
                // The final accepted line stops fetching and arms the pipeline drain
                if (last_s) begin
                    state_s = S_DRAIN;
                    drain_s = DRAIN_INIT;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (drain_r == {DW{1'b0}}) begin
                    state_s = S_IDLE;
                    done_s  = 1'b1;
                end else begin
                    drain_s = drain_r - DW'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        busy_s = (state_s != S_IDLE);
        req_s  = (state_s == S_PRIME) || (state_s == S_RUN);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            n_r     <= {CW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            drain_r <= {DW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            req_r   <= 1'b0;
            fv_r    <= 1'b0;
            rv_r    <= 1'b0;
            last_r  <= 1'b0;
            idx_r   <= 5'd0;
        end else begin
            state_r <= state_s;
            n_r     <= n_s;
            cnt_r   <= cnt_s;
            drain_r <= drain_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
            req_r   <= req_s;
            fv_r    <= fv_s;
            rv_r    <= rv_s;
            last_r  <= last_s;
            idx_r   <= idx_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign line_req     = req_r;
    assign filter_valid = fv_r;
    assign ref_valid    = rv_r;
    assign last_line    = last_r;
    assign line_idx     = idx_r;

endmodule

// File: tb/tb_frac_search_ctrl.sv
// Bench for frac_search_ctrl: table of block scenarios driven through a cycle-level
// reference, with expected line strobes queued at acceptance and checked on arrival.
module tb_frac_search_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [4:0] blk_h = 5'd0;
    logic       line_ack = 1'b0;
    logic       busy, done, err, line_req, filter_valid, ref_valid, last_line;
    logic [4:0] line_idx;

    frac_search_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .blk_h(blk_h),
        .busy(busy), .done(done), .err(err), .line_req(line_req),
        .line_ack(line_ack), .filter_valid(filter_valid), .ref_valid(ref_valid),
        .line_idx(line_idx), .last_line(last_line)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] h;
        int         period;
        bit         extra_start;
        bit         drain_ack;
        int         tail;
        int         exp_lines;
        int         exp_err;
    } vec_t;

    typedef struct {
        logic [4:0] idx;
        logic       rv;
        logic       last;
    } strobe_t;

    strobe_t sq[$];
    int checks = 0;
    int fails  = 0;
    bit m_busy = 1'b0;
    bit m_req  = 1'b0;
    int m_n = 0, m_cnt = 0, m_drain = 0;
    int cyc = 0;
    int lines_seen, err_seen, done_seen, last_cyc, done_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: predict the outcome of these inputs, clock them in, compare
    task automatic step(input logic st, input logic [4:0] h, input logic ack);
        bit      e_err, e_done;
        strobe_t s;
        start = st;
        blk_h = h;
        line_ack = ack;
        e_err = 1'b0;
        e_done = 1'b0;
        if (!m_busy) begin
            if (st) begin
                if (h >= 5'd1 && h <= 5'd16) begin
                    m_busy = 1'b1; m_req = 1'b1; m_n = int'(h) + 7; m_cnt = 0;
                end else begin
                    e_err = 1'b1;
                end
            end
        end else if (m_req) begin
            if (ack) begin
                s.idx = m_cnt[4:0];
                s.rv = (m_cnt >= 7);
                s.last = (m_cnt == m_n - 1);
                sq.push_back(s);
                m_cnt++;
                if (m_cnt == m_n) begin
                    m_req = 1'b0;
                    m_drain = 4;
                end
            end
        end else begin
            if (m_drain == 0) begin
                e_done = 1'b1;
                m_busy = 1'b0;
            end else begin
                m_drain--;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("busy", busy, m_busy);
        check("line_req", line_req, m_req);
        check("done", done, e_done);
        check("err", err, e_err);
        if (err) err_seen++;
        if (done) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (filter_valid) begin
            check("strobe_expected", sq.size() > 0, 1);
            if (sq.size() > 0) begin
                s = sq.pop_front();
                check("line_idx", line_idx, s.idx);
                check("ref_valid", ref_valid, s.rv);
                check("last_line", last_line, s.last);
                lines_seen++;
                if (last_line) last_cyc = cyc;
            end
        end else begin
            check("ref_without_filter", ref_valid, 0);
            check("last_without_filter", last_line, 0);
            check("missing_strobe", sq.size(), 0);
            sq.delete();
        end
        start = 1'b0;
        line_ack = 1'b0;
    endtask

    task automatic run_block(input vec_t v);
        bit         a;
        bit         xs;
        lines_seen = 0; err_seen = 0; done_seen = 0; last_cyc = -1; done_cyc = -1;
        step(1'b1, v.h, 1'b0);
        for (int i = 0; i < 300 && m_busy; i++) begin
            a = ((i % v.period) == v.period - 1);
            if (v.drain_ack && m_busy && !m_req) a = 1'b1;
            xs = v.extra_start && (i == 2);
            step(xs, xs ? 5'd3 : 5'd0, a);
        end
        check("block_finished", m_busy, 0);
        for (int t = 0; t < v.tail; t++) step(1'b0, 5'd0, 1'b0);
        check("line_count", lines_seen, v.exp_lines);
        check("err_count", err_seen, v.exp_err);
        check("done_count", done_seen, (v.exp_lines > 0) ? 1 : 0);
        if (v.exp_lines > 0) check("done_latency", done_cyc - last_cyc, 5);
    endtask

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{5'd4,  1, 1'b0, 1'b0, 2, 11, 0};
        tbl[1] = '{5'd1,  3, 1'b0, 1'b0, 2,  8, 0};
        tbl[2] = '{5'd0,  1, 1'b0, 1'b0, 2,  0, 1};
        tbl[3] = '{5'd17, 1, 1'b0, 1'b0, 2,  0, 1};
        tbl[4] = '{5'd16, 1, 1'b0, 1'b0, 2, 23, 0};
        tbl[5] = '{5'd2,  2, 1'b1, 1'b1, 2,  9, 0};
        tbl[6] = '{5'd31, 1, 1'b0, 1'b0, 2,  0, 1};

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_line_req", line_req, 0);
        check("rst_filter_valid", filter_valid, 0);
        check("rst_line_idx", line_idx, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) run_block(tbl[k]);

        // Asynchronous reset in the middle of a block
        lines_seen = 0;
        step(1'b1, 5'd4, 1'b0);
        for (int i = 0; i < 20 && lines_seen < 4; i++) step(1'b0, 5'd0, 1'b1);
        check("lines_before_reset", lines_seen, 4);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_line_req", line_req, 0);
        check("arst_filter_valid", filter_valid, 0);
        check("arst_ref_valid", ref_valid, 0);
        check("arst_last_line", last_line, 0);
        check("arst_line_idx", line_idx, 0);
        check("arst_done", done, 0);
        m_busy = 1'b0; m_req = 1'b0; sq.delete();
        step(1'b0, 5'd0, 1'b1);
        step(1'b0, 5'd0, 1'b1);
        reset = 1'b1;
        run_block('{5'd2, 1, 1'b0, 1'b0, 2, 9, 0});

        // Start in the cycle right after done
        run_block('{5'd1, 1, 1'b0, 1'b0, 0, 8, 0});
        run_block('{5'd3, 1, 1'b0, 1'b0, 2, 10, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/frac_search_ctrl.md
Name: frac_search_ctrl

Overview:
- Sequencer for the fractional motion-search datapath.
- On a start command, requests the block's filter lines from the line fetcher one at a time, one line per accepted handshake.
- Tags each delivered line for the datapath:
  - the first TAPS-1 lines are prime-only (filter taps fill);
  - every later line also carries a reference line.
- After the last line it waits for the datapath pipeline to drain, then signals done.

Parameters:
- TAPS, 8, interpolation filter taps; number of prime-only lines = TAPS-1.
- HMAX, 16, maximum block height in lines.
- PIPE_LAT, 4, datapath latency in cycles from the last line strobe to a valid result.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command to begin a block; sampled only in IDLE.
- blk_h  input  5  block height in lines, sampled with start; legal range 1..HMAX.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the block result is valid.
- err  output  1  one-cycle pulse when start is given with an illegal blk_h.
- line_req  output  1  request to the fetcher for the next filter line.
- line_ack  input  1  fetcher has delivered the line; counts only while line_req=1.
- filter_valid  output  1  strobe telling the datapath to shift in a filter line.
- ref_valid  output  1  strobe telling the datapath to consume a reference line; implies filter_valid.
- line_idx  output  5  index of the line strobed this cycle (0-based).
- last_line  output  1  qualifies filter_valid for the final line of the block.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE;
  - all counters = 0;
  - busy, done, err, line_req, filter_valid, ref_valid, last_line = 0;
  - line_idx = 0.
  - Reset asserted mid-block abandons the block immediately; no done pulse is produced.
- Internal values: N = blk_h + TAPS - 1 (total filter lines), latched at start. Counter cnt counts accepted lines.
- State IDLE:
  - start=1 with blk_h in 1..HMAX: latch N, cnt=0; next state PRIME (or RUN when TAPS=1); line_req=1 from the next cycle.
  - start=1 with blk_h=0 or blk_h>HMAX: err=1 for one cycle, remain in IDLE.
- Accepted line: a cycle with line_req=1 and line_ack=1. On the following cycle:
  - filter_valid=1 and line_idx=cnt;
  - ref_valid=1 only if cnt >= TAPS-1;
  - last_line=1 only if cnt == N-1;
  - cnt increments.
- Strobes are one-cycle registered pulses.
- Throughput is one line per cycle: line_req stays high across back-to-back acks.
- State PRIME: transition to RUN when the accepted line makes cnt reach TAPS-1.
- State RUN: when the accepted line is line N-1:
  - line_req drops on the next cycle;
  - state moves to DRAIN with the drain counter = PIPE_LAT.
- line_ack while line_req=0 is ignored: no strobe, no count.
- State DRAIN:
  - drain counter decrements each cycle;
  - on reaching 0: done=1 for one cycle, busy=0 on the same cycle, and the state returns to IDLE.
  - done fires exactly PIPE_LAT+1 cycles after the last_line strobe.
- start while busy=1 is ignored: no err, no relatch.
- A start in the cycle after done is accepted.
- Widths:
  - N needs at most 5 bits for the defaults (max 23); the counter is sized to hold HMAX+TAPS-1.
  - line_idx reports the low 5 bits.

Test Plan:
- Nominal block: blk_h=4, TAPS=8, line_ack tied to 1 → 11 filter_valid pulses on consecutive cycles with line_idx 0..10; ref_valid high on idx 7..10 only; last_line on idx 10; done exactly 5 cycles after the idx-10 strobe; busy falls with done.
- Fetcher stalls: blk_h=1, line_ack high only every third cycle → 8 strobes, each one cycle after its ack; line_req held high throughout the gaps; ref_valid only on idx 7; done 5 cycles after that strobe.
- Illegal heights: start with blk_h=0, then with blk_h=17 → err pulses twice, busy stays 0, no line_req; a following start with blk_h=16 runs 23 lines.
- Ignored commands: second start while busy, and line_ack while line_req=0 during DRAIN → no count change, no extra strobe, exactly one done.
- Reset mid-run: reset=0 asynchronously after idx 3 → outputs clear immediately, without a clock edge; after release, a fresh start with blk_h=2 yields 9 lines from idx 0.
- Back-to-back blocks: start asserted in the cycle after done → accepted; the second block's line_req rises the next cycle.
